// File: rtl/mux32_1.sv
// Dual-read-port operand selector: two independent 32:1 muxes over the
// architectural register values, each feeding an enable-gated output register.

module mux32_port #(
  parameter int NUM_REGS = 32,
  parameter int VEC_W    = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               en,
  input  logic [NUM_REGS-1:0][VEC_W-1:0]     regs,
  input  logic [$clog2(NUM_REGS)-1:0]        sel,
  output logic [VEC_W-1:0]                   q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= regs[sel];
  end
endmodule

module mux32_1 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_1,
  input  logic [31:0] in_2,
  input  logic [31:0] in_3,
  input  logic [31:0] in_4,
  input  logic [31:0] in_5,
  input  logic [31:0] in_6,
  input  logic [31:0] in_7,
  input  logic [31:0] in_8,
  input  logic [31:0] in_9,
  input  logic [31:0] in_10,
  input  logic [31:0] in_11,
  input  logic [31:0] in_12,
  input  logic [31:0] in_13,
  input  logic [31:0] in_14,
  input  logic [31:0] in_15,
  input  logic [31:0] in_16,
  input  logic [31:0] in_17,
  input  logic [31:0] in_18,
  input  logic [31:0] in_19,
  input  logic [31:0] in_20,
  input  logic [31:0] in_21,
  input  logic [31:0] in_22,
  input  logic [31:0] in_23,
  input  logic [31:0] in_24,
  input  logic [31:0] in_25,
  input  logic [31:0] in_26,
  input  logic [31:0] in_27,
  input  logic [31:0] in_28,
  input  logic [31:0] in_29,
  input  logic [31:0] in_30,
  input  logic [31:0] in_31,
  input  logic [31:0] in_32,
  input  logic [4:0]  selrs1,
  input  logic [4:0]  selrs2,
  input  logic        reg_select,
  output logic [31:0] data_out1,
  output logic [31:0] data_out2
);
  localparam int NUM_PORTS = 2;
  localparam int NUM_REGS  = 32;
  localparam int VEC_W     = 32;

  logic [NUM_REGS-1:0][VEC_W-1:0]  regs;
  logic [NUM_PORTS-1:0][4:0]       sel;
  logic [NUM_PORTS-1:0][VEC_W-1:0] q;

  // in_1 lands at index 0 so that select code k addresses in_(k+1)
  assign regs = {in_32, in_31, in_30, in_29, in_28, in_27, in_26, in_25,
                 in_24, in_23, in_22, in_21, in_20, in_19, in_18, in_17,
                 in_16, in_15, in_14, in_13, in_12, in_11, in_10, in_9,
                 in_8,  in_7,  in_6,  in_5,  in_4,  in_3,  in_2,  in_1};
  assign sel  = {selrs2, selrs1};

  generate
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
      mux32_port #(.NUM_REGS(NUM_REGS), .VEC_W(VEC_W)) u_port (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (reg_select),
        .regs  (regs),
        .sel   (sel[g]),
        .q     (q[g])
      );
    end
  endgenerate

  assign data_out1 = q[0];
  assign data_out2 = q[1];
endmodule

// File: tb/tb_mux32_1.sv
// Randomized and directed bench for mux32_1 with a behavioural read-port model.

module tb_mux32_1;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ins [32];
  logic [4:0]  selrs1 = '0, selrs2 = '0;
  logic        reg_select = 1'b0;
  logic [31:0] data_out1, data_out2;
  logic [31:0] m1, m2;
  bit          cmp_en = 1'b0;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  mux32_1 dut (
    .clk(clk), .rst_n(rst_n),
    .in_1(ins[0]),   .in_2(ins[1]),   .in_3(ins[2]),   .in_4(ins[3]),
    .in_5(ins[4]),   .in_6(ins[5]),   .in_7(ins[6]),   .in_8(ins[7]),
    .in_9(ins[8]),   .in_10(ins[9]),  .in_11(ins[10]), .in_12(ins[11]),
    .in_13(ins[12]), .in_14(ins[13]), .in_15(ins[14]), .in_16(ins[15]),
    .in_17(ins[16]), .in_18(ins[17]), .in_19(ins[18]), .in_20(ins[19]),
    .in_21(ins[20]), .in_22(ins[21]), .in_23(ins[22]), .in_24(ins[23]),
    .in_25(ins[24]), .in_26(ins[25]), .in_27(ins[26]), .in_28(ins[27]),
    .in_29(ins[28]), .in_30(ins[29]), .in_31(ins[30]), .in_32(ins[31]),
    .selrs1(selrs1), .selrs2(selrs2), .reg_select(reg_select),
    .data_out1(data_out1), .data_out2(data_out2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each enabled edge reads the register file array by address.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 = 32'h0;
      m2 = 32'h0;
    end else if (reg_select) begin
      m1 = ins[selrs1];
      m2 = ins[selrs2];
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_out1", data_out1, m1);
      check("model_out2", data_out2, m2);
    end
  end

  task automatic drive(input logic [4:0] s1, input logic [4:0] s2, input logic en);
    selrs1 = s1;
    selrs2 = s2;
    reg_select = en;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 32; k++) ins[k] = 32'hAAAA_0001 + k;
    reg_select = 1'b1;
    repeat (3) tick();
    check("reset_hold_out1", data_out1, 32'h0);
    check("reset_hold_out2", data_out2, 32'h0);
    cmp_en = 1'b1;
    rst_n = 1'b1;

    // Full sweep with both ports on the same address
    for (int s = 0; s < 32; s++) begin
      drive(5'(s), 5'(s), 1'b1);
      tick();
      check("sweep_out1", data_out1, 32'hAAAA_0001 + s);
      check("sweep_out2", data_out2, 32'hAAAA_0001 + s);
    end
    check("sweep_last", data_out1, 32'hAAAA_0020);

    drive(5'd3, 5'd28, 1'b1);
    tick();
    check("indep_out1", data_out1, 32'hAAAA_0004);
    check("indep_out2", data_out2, 32'hAAAA_001D);

    // Hold: enable low freezes outputs despite select and data changes
    drive(5'd5, 5'd5, 1'b1);
    tick();
    check("hold_cap", data_out1, 32'hAAAA_0006);
    drive(5'd10, 5'd10, 1'b0);
    ins[5] = 32'h1234_5678;
    repeat (3) begin
      tick();
      check("hold_out1", data_out1, 32'hAAAA_0006);
      check("hold_out2", data_out2, 32'hAAAA_0006);
    end
    reg_select = 1'b1;
    tick();
    check("hold_release1", data_out1, 32'hAAAA_000B);
    check("hold_release2", data_out2, 32'hAAAA_000B);
    ins[5] = 32'hAAAA_0006;

    // Alternating enable with incrementing selects
    for (int i = 0; i < 16; i++) begin
      drive(5'(i), 5'(31 - i), (i % 2) == 0);
      tick();
      check("alt_out1", data_out1, 32'hAAAA_0001 + (i - (i % 2)));
    end

    // Wrap from 31 back to 0
    drive(5'd31, 5'd31, 1'b1);
    tick();
    drive(5'd0, 5'd0, 1'b1);
    tick();
    check("wrap_out1", data_out1, 32'hAAAA_0001);
    check("wrap_out2", data_out2, 32'hAAAA_0001);

    // Asynchronous reset mid-cycle
    drive(5'd7, 5'd9, 1'b1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out1", data_out1, 32'h0);
    check("async_rst_out2", data_out2, 32'h0);
    #2 rst_n = 1'b1;

    // Randomized phase with occasional mid-cycle resets
    for (int n = 0; n < 400; n++) begin
      tick();
      for (int k = 0; k < 32; k++) ins[k] = $urandom;
      drive(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) begin
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
